// File: rtl/mac_t_frame_writer.sv
// mac_t_frame_writer
// Byte-stream front end for the GMII transmit MAC. Each incoming frame is
// steered to either the normal or the TTE FIFO pair. A frame is admitted only
// when the chosen pair has room for a full max-size frame. Bytes past MAX_LEN
// are consumed but not written. A pointer word {5'b0, len} is pushed once the
// frame is closed.
module mac_t_frame_writer #(
    parameter int unsigned MAX_LEN  = 1518,
    parameter int unsigned DEPTH_TH = 2578
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_tte,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_din,
    input  logic [11:0] data_fifo_depth,
    output logic        ptr_fifo_wr,
    output logic [15:0] ptr_fifo_din,
    input  logic        ptr_fifo_full,
    output logic        tdata_fifo_wr,
    output logic [7:0]  tdata_fifo_din,
    input  logic [11:0] tdata_fifo_depth,
    output logic        tptr_fifo_wr,
    output logic [15:0] tptr_fifo_din,
    input  logic        tptr_fifo_full,
    output logic [15:0] frm_cnt,
    output logic [15:0] tte_frm_cnt,
    output logic        err_trunc,
    output logic        err_framing
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CLOSE = 2'd2;

    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [11:0] TH      = 12'(DEPTH_TH);
    localparam logic [10:0] LEN_SAT = '1;

    logic [1:0]  state;
    logic        close_2nd;
    logic        sel_tte;
    logic [10:0] len;

    logic        sel_full;
    logic [11:0] sel_depth;
    logic        admit;
    logic        accept;
    logic        wr_tte;
    logic        wr_byte;
    logic [10:0] ptr_len;

    // Admission check, handshake and per-byte write decision
    always_comb begin
        sel_full  = in_tte ? tptr_fifo_full : ptr_fifo_full;
        sel_depth = in_tte ? tdata_fifo_depth : data_fifo_depth;
        admit     = !sel_full && (sel_depth <= TH);
        in_ready  = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  in_ready = !(in_valid && in_sop) || admit;
                S_WRITE: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
        accept  = in_valid && in_ready;
        wr_tte  = (state == S_IDLE) ? in_tte : sel_tte;
        wr_byte = accept && ((state == S_IDLE) ? in_sop : (len < MAX_L));
        ptr_len = (len > MAX_L) ? MAX_L : len;
    end

    // Frame FSM, registered FIFO strobes, counters and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            close_2nd      <= 1'b0;
            sel_tte        <= 1'b0;
            len            <= '0;
            data_fifo_wr   <= 1'b0;
            data_fifo_din  <= '0;
            ptr_fifo_wr    <= 1'b0;
            ptr_fifo_din   <= '0;
            tdata_fifo_wr  <= 1'b0;
            tdata_fifo_din <= '0;
            tptr_fifo_wr   <= 1'b0;
            tptr_fifo_din  <= '0;
            frm_cnt        <= '0;
            tte_frm_cnt    <= '0;
            err_trunc      <= 1'b0;
            err_framing    <= 1'b0;
        end else begin
            data_fifo_wr  <= 1'b0;
            tdata_fifo_wr <= 1'b0;
            ptr_fifo_wr   <= 1'b0;
            tptr_fifo_wr  <= 1'b0;
            err_trunc     <= 1'b0;
            err_framing   <= 1'b0;

            if (wr_byte) begin
                if (wr_tte) begin
                    tdata_fifo_wr  <= 1'b1;
                    tdata_fifo_din <= in_data;
                end else begin
                    data_fifo_wr  <= 1'b1;
                    data_fifo_din <= in_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (in_sop) begin
                            sel_tte   <= in_tte;
                            len       <= 11'd1;
                            close_2nd <= 1'b0;
                            state     <= in_eop ? S_CLOSE : S_WRITE;
                        end else begin
                            err_framing <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        if (in_sop) err_framing <= 1'b1;
                        if (len != LEN_SAT) len <= len + 11'd1;
                        if (in_eop) begin
                            close_2nd <= 1'b0;
                            state     <= S_CLOSE;
                        end
                    end
                end
                S_CLOSE: begin
                    // First close cycle issues the pointer; second is the settle gap
                    if (!close_2nd) begin
                        close_2nd <= 1'b1;
                        err_trunc <= (len > MAX_L);
                        if (sel_tte) begin
                            tptr_fifo_wr  <= 1'b1;
                            tptr_fifo_din <= {5'b0, ptr_len};
                            tte_frm_cnt   <= tte_frm_cnt + 16'd1;
                        end else begin
                            ptr_fifo_wr  <= 1'b1;
                            ptr_fifo_din <= {5'b0, ptr_len};
                            frm_cnt      <= frm_cnt + 16'd1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
